// File: rtl/seg_scan_bin_dri.sv
// Binary-to-BCD (sequential double dabble) multiplexed common-anode display driver.
// Optional macro SEG_SIGN_EN adds a sign input and a leading '-' digit.
module seg_scan_bin_dri #(
    parameter int unsigned NUM_DIG   = 6,
    parameter int unsigned BIN_W     = 20,
    parameter int unsigned CLK_FREQ  = 9_000_000,
    parameter int unsigned SCAN_FREQ = 1_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BIN_W-1:0]   bin,
    input  logic               bin_vld,
`ifdef SEG_SIGN_EN
    input  logic               sign,
`endif
    input  logic [NUM_DIG-1:0] point,
    input  logic               en,
    output logic               busy,
    output logic               overflow,
    output logic [NUM_DIG-1:0] sel,
    output logic [7:0]         seg_led
);

    localparam int unsigned BCD_W = NUM_DIG * 4;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned DIV   = (CLK_FREQ / SCAN_FREQ > 0) ? CLK_FREQ / SCAN_FREQ : 1;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT_ALL = pow10(NUM_DIG);
`ifdef SEG_SIGN_EN
    localparam logic [63:0] LIMIT_NEG = pow10(NUM_DIG - 1);
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t             state;
    logic [BIN_W-1:0]   sh_q;
    logic [BIN_W-1:0]   cap_q;
    logic [BIN_W-1:0]   pend_q;
    logic               pend_vld_q;
    logic [BCD_W-1:0]   acc_q;
    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   disp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   idx_q;
    logic               tick;
    logic               ovf_calc;
    logic [NUM_DIG:0]   blank;
    logic [3:0]         cur_dig;
    logic [7:0]         seg_nxt;
`ifdef SEG_SIGN_EN
    logic               sign_pend_q;
    logic               sign_cap_q;
    logic               neg_q;
    logic [NUM_DIG-1:0] sgn_pos;
`endif

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
        end
    end

`ifdef SEG_SIGN_EN
    assign ovf_calc = (64'(cap_q) >= LIMIT_ALL) || (sign_cap_q && (64'(cap_q) >= LIMIT_NEG));
`else
    assign ovf_calc = 64'(cap_q) >= LIMIT_ALL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            sh_q       <= '0;
            cap_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            acc_q      <= '0;
            disp_q     <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
`ifdef SEG_SIGN_EN
            sign_pend_q <= 1'b0;
            sign_cap_q  <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else begin
            if (bin_vld && state != StIdle) begin
                pend_q     <= bin;
                pend_vld_q <= 1'b1;
`ifdef SEG_SIGN_EN
                sign_pend_q <= sign;
`endif
            end
            unique case (state)
                StIdle: begin
                    // A fresh strobe supersedes any older pending value.
                    if (bin_vld || pend_vld_q) begin
                        sh_q       <= bin_vld ? bin : pend_q;
                        cap_q      <= bin_vld ? bin : pend_q;
                        pend_vld_q <= 1'b0;
                        busy       <= 1'b1;
                        state      <= StLoad;
`ifdef SEG_SIGN_EN
                        sign_cap_q <= bin_vld ? sign : sign_pend_q;
`endif
                    end
                end
                StLoad: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    state <= StShift;
                end
                StShift: begin
                    acc_q <= BCD_W'({acc_adj, sh_q[BIN_W-1]});
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) state <= StDone;
                end
                StDone: begin
                    disp_q   <= acc_q;
                    overflow <= ovf_calc;
                    busy     <= 1'b0;
                    state    <= StIdle;
`ifdef SEG_SIGN_EN
                    neg_q    <= sign_cap_q && (cap_q != '0);
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (tick) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // blank[i]: digit i and everything above it are zero with no point set.
    always_comb begin
        blank          = '0;
        blank[NUM_DIG] = 1'b1;
        for (int i = NUM_DIG - 1; i >= 1; i--) begin
            blank[i] = blank[i+1] && (disp_q[i*4 +: 4] == 4'd0) && !point[i];
        end
    end

`ifdef SEG_SIGN_EN
    always_comb begin
        sgn_pos = '0;
        for (int i = 1; i < NUM_DIG; i++) sgn_pos[i] = blank[i] && !blank[i-1];
    end
`endif

    assign cur_dig = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        seg_nxt = {~point[idx_q], seg7(cur_dig)};
        if (blank[idx_q]) seg_nxt[6:0] = 7'h7F;
`ifdef SEG_SIGN_EN
        if (neg_q && sgn_pos[idx_q]) seg_nxt = 8'hBF;
`endif
        if (overflow) seg_nxt = 8'hBF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '1;
            seg_led <= 8'hFF;
        end else if (!en) begin
            sel     <= '1;
            seg_led <= 8'hFF;
        end else begin
            sel     <= ~(NUM_DIG'(1) << idx_q);
            seg_led <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_bin_dri.sv
// Directed, table-driven bench for seg_scan_bin_dri (6 digits, 20-bit input, 8-clock scan step).
module tb_seg_scan_bin_dri;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [19:0] bin = '0;
    logic        bin_vld = 1'b0;
    logic [5:0]  point = '0;
    logic        en = 1'b1;
    logic        busy;
    logic        overflow;
    logic [5:0]  sel;
    logic [7:0]  seg_led;
`ifdef SEG_SIGN_EN
    logic        sign = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_bin_dri #(
        .NUM_DIG   (6),
        .BIN_W     (20),
        .CLK_FREQ  (8),
        .SCAN_FREQ (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin      (bin),
        .bin_vld  (bin_vld),
`ifdef SEG_SIGN_EN
        .sign     (sign),
`endif
        .point    (point),
        .en       (en),
        .busy     (busy),
        .overflow (overflow),
        .sel      (sel),
        .seg_led  (seg_led)
    );

    typedef struct packed {
        logic [19:0] bin;
        logic [5:0]  point;
        logic        en;
        logic        ovf;
        logic [47:0] segs;  // {d5,d4,d3,d2,d1,d0}
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sel === ~(6'b1 << d)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout($sformatf("digit%0d_sel", d));
        else check($sformatf("digit%0d_seg", d), 32'(seg_led), 32'(exp));
    endtask

    // Strobe one value, then count the sampled busy-high cycles until it drops.
    task automatic strobe_timed(input logic [19:0] b, output int nbusy);
        @(negedge clk);
        bin     = b;
        bin_vld = 1'b1;
        @(negedge clk);
        bin_vld = 1'b0;
        nbusy   = 0;
        for (int n = 0; n < 100; n++) begin
            if (!busy) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic wait_window_start(output bit ok);
        bit left;
        left = 1'b0;
        ok   = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sel !== 6'b111110) left = 1'b1;
            else if (left) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  nb;
        int  lows;
        int  bad;
        bit  ok;

        vecs[0]  = {20'd123456,  6'b000000, 1'b1, 1'b0, 48'hF9A4B0999282};
        vecs[1]  = {20'd42,      6'b000000, 1'b1, 1'b0, 48'hFFFFFFFF99A4};
        vecs[2]  = {20'd42,      6'b000100, 1'b1, 1'b0, 48'hFFFFFF4099A4};
        vecs[3]  = {20'd1000000, 6'b000000, 1'b1, 1'b1, 48'hBFBFBFBFBFBF};
        vecs[4]  = {20'd999999,  6'b000000, 1'b1, 1'b0, 48'h909090909090};
        vecs[5]  = {20'd0,       6'b000000, 1'b1, 1'b0, 48'hFFFFFFFFFFC0};
        vecs[6]  = {20'd7,       6'b100000, 1'b1, 1'b0, 48'h40C0C0C0C0F8};
        vecs[7]  = {20'd123456,  6'b000000, 1'b0, 1'b0, 48'hFFFFFFFFFFFF};
        vecs[8]  = {20'd1048575, 6'b000000, 1'b1, 1'b1, 48'hBFBFBFBFBFBF};
        vecs[9]  = {20'd100000,  6'b000000, 1'b1, 1'b0, 48'hF9C0C0C0C0C0};
        vecs[10] = {20'd305,     6'b000001, 1'b1, 1'b0, 48'hFFFFFFB0C012};

        #1 rst_n = 1'b0;
        #1;
        check("reset_sel", 32'(sel), 32'h3F);
        check("reset_seg", 32'(seg_led), 32'hFF);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            point = vecs[v].point;
            en    = vecs[v].en;
            strobe_timed(vecs[v].bin, nb);
            check($sformatf("v%0d_busy_len", v), 32'(nb), 32'd22);
            check($sformatf("v%0d_ovf", v), 32'(overflow), 32'(vecs[v].ovf));
            if (vecs[v].en) begin
                for (int d = 0; d < 6; d++) check_digit(d, vecs[v].segs[d*8 +: 8]);
            end else begin
                bad = 0;
                repeat (60) begin
                    @(negedge clk);
                    if (sel !== 6'h3F || seg_led !== 8'hFF) bad++;
                end
                check($sformatf("v%0d_en_off", v), 32'(bad), 32'd0);
            end
        end
        en    = 1'b1;
        point = '0;

        // Back-to-back strobes 7, 8, 9: 7 is shown, 8 is overwritten, 9 follows.
        wait_window_start(ok);
        if (!ok) timeout("b2b_window");
        repeat (25) @(negedge clk);
        bin     = 20'd7;
        bin_vld = 1'b1;
        lows    = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) bin = 20'd8;
            if (i == 2) bin = 20'd9;
            if (i == 3) bin_vld = 1'b0;
            if (!busy) lows++;
            if (i == 27) begin
                check("b2b_first_sel", 32'(sel), 32'h3E);
                check("b2b_first_seg", 32'(seg_led), 32'hF8);
            end
        end
        check("b2b_idle_cycles", 32'(lows), 32'd1);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("b2b_busy_fall");
        check_digit(0, 8'h90);
        check_digit(1, 8'hFF);
        check("b2b_ovf", 32'(overflow), 32'h0);

        // Reset mid-SHIFT discards the conversion and any pending state.
        strobe_timed(20'd1000000, nb);
        check("pre_rst_ovf", 32'(overflow), 32'h1);
        @(negedge clk);
        bin     = 20'd123456;
        bin_vld = 1'b1;
        @(negedge clk);
        bin     = 20'd654321;
        repeat (8) @(negedge clk);
        bin_vld = 1'b0;
        check("mid_shift_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_sel", 32'(sel), 32'h3F);
        check("rst_mid_seg", 32'(seg_led), 32'hFF);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_ovf", 32'(overflow), 32'h0);
        check_digit(0, 8'hC0);
        check_digit(1, 8'hFF);

`ifdef SEG_SIGN_EN
        sign = 1'b1;
        strobe_timed(20'd5, nb);
        check("neg5_ovf", 32'(overflow), 32'h0);
        check_digit(0, 8'h92);
        check_digit(1, 8'hBF);
        check_digit(2, 8'hFF);
        strobe_timed(20'd123456, nb);
        check("neg_big_ovf", 32'(overflow), 32'h1);
        strobe_timed(20'd0, nb);
        check("neg0_ovf", 32'(overflow), 32'h0);
        check_digit(0, 8'hC0);
        check_digit(1, 8'hFF);
        sign = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
